// File: rtl/alien_pkg.sv
// Shared formation geometry, state encoding and cell indexing for the alien hit tracker.
package alien_pkg;

  localparam int ROWS        = 5;
  localparam int COLS        = 11;
  localparam int CELL_W_LOG2 = 5;
  localparam int CELL_H_LOG2 = 5;

  typedef logic [ROWS*COLS-1:0] alive_mask_t;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    LATCHED = 2'd1,
    COMMIT  = 2'd2
  } hit_state_t;

  function automatic int unsigned cell_idx(input int unsigned row, input int unsigned col,
                                           input int unsigned cols = COLS);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/frame_edge_sync.sv
// Brings the asynchronous frame strobe into the Clk domain and emits a one-cycle rising-edge pulse.
module frame_edge_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_edge_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_edge_q <= 1'b0;
    end else begin
      r_sync1  <= i_async;
      r_sync2  <= r_sync1;
      r_edge_q <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_edge_q;

endmodule

// File: rtl/alien_hit_tracker.sv
// Finds the first alien/missile overlap of each frame, maps it to a formation cell and
// retires that alien on the following frame edge.
module alien_hit_tracker
  import alien_pkg::*;
#(
  parameter int ROWS        = alien_pkg::ROWS,
  parameter int COLS        = alien_pkg::COLS,
  parameter int CELL_W_LOG2 = alien_pkg::CELL_W_LOG2,
  parameter int CELL_H_LOG2 = alien_pkg::CELL_H_LOG2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic                 is_alien,
  input  logic                 is_missile,
  input  logic [9:0]           grid_x,
  input  logic [9:0]           grid_y,
  input  logic                 new_wave,
  output logic [ROWS*COLS-1:0] alive_mask,
  output logic                 hit_valid,
  output logic [2:0]           hit_row,
  output logic [3:0]           hit_col,
  output logic                 all_dead
);

  localparam int             N     = ROWS * COLS;
  localparam logic [10:0]    W_LIM = 11'(COLS << CELL_W_LOG2);
  localparam logic [10:0]    H_LIM = 11'(ROWS << CELL_H_LOG2);
  localparam logic [N-1:0]   ONE   = N'(1);

  logic          w_frame_edge;
  logic [10:0]   w_ox;
  logic [10:0]   w_oy;
  logic [3:0]    w_col;
  logic [2:0]    w_row;
  logic          w_in_grid;
  logic [N-1:0]  w_cell_bit;
  logic [N-1:0]  w_pend_bit;
  logic          w_overlap;

  hit_state_t    r_state;
  logic [N-1:0]  r_alive;
  logic [2:0]    r_pend_row;
  logic [3:0]    r_pend_col;
  logic          r_hit_valid;
  logic [2:0]    r_hit_row;
  logic [3:0]    r_hit_col;
  logic          r_all_dead;

  frame_edge_sync u_frame_edge_sync (
    .i_clk   (Clk),
    .i_reset (Reset),
    .i_async (frame_clk),
    .o_rise  (w_frame_edge)
  );

  // Bit 10 of each offset is the borrow, i.e. the pixel lies left of / above the grid.
  assign w_ox      = {1'b0, DrawX} - {1'b0, grid_x};
  assign w_oy      = {1'b0, DrawY} - {1'b0, grid_y};
  assign w_col     = 4'(w_ox >> CELL_W_LOG2);
  assign w_row     = 3'(w_oy >> CELL_H_LOG2);
  assign w_in_grid = !w_ox[10] && !w_oy[10] && (w_ox < W_LIM) && (w_oy < H_LIM);

  assign w_cell_bit = ONE << cell_idx(32'(w_row), 32'(w_col), COLS);
  assign w_pend_bit = ONE << cell_idx(32'(r_pend_row), 32'(r_pend_col), COLS);
  assign w_overlap  = is_alien && is_missile && w_in_grid && (|(r_alive & w_cell_bit));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= SCAN;
      r_alive     <= '1;
      r_pend_row  <= 3'd0;
      r_pend_col  <= 4'd0;
      r_hit_valid <= 1'b0;
      r_hit_row   <= 3'd0;
      r_hit_col   <= 4'd0;
      r_all_dead  <= 1'b0;
    end else begin
      r_hit_valid <= 1'b0;
      r_all_dead  <= (r_alive == '0);
      if (new_wave) begin
        r_alive <= '1;
        r_state <= SCAN;
      end else begin
        case (r_state)
          // An overlap arriving with the frame edge belongs to a frame that has already ended.
          SCAN: begin
            if (!w_frame_edge && w_overlap) begin
              r_pend_row <= w_row;
              r_pend_col <= w_col;
              r_state    <= LATCHED;
            end
          end
          LATCHED: begin
            if (w_frame_edge) begin
              r_state <= COMMIT;
            end
          end
          COMMIT: begin
            r_alive     <= r_alive & ~w_pend_bit;
            r_hit_row   <= r_pend_row;
            r_hit_col   <= r_pend_col;
            r_hit_valid <= 1'b1;
            r_state     <= SCAN;
          end
          default: r_state <= SCAN;
        endcase
      end
    end
  end

  assign alive_mask = r_alive;
  assign hit_valid  = r_hit_valid;
  assign hit_row    = r_hit_row;
  assign hit_col    = r_hit_col;
  assign all_dead   = r_all_dead;

endmodule
